// File: rtl/ldtu_ser_nch.sv
// Multi-lane word serializer: loads one word per lane every WORD cycles
// and shifts it out MSB- or LSB-first, with handshake and underrun count.
// Ports: clock, rst_b (async low); data_in/data_valid/sync_mode/
// sync_pattern/ch_enable/msb_first/underrun_clr in;
// handshake, data_out[NCH], underrun_cnt[8] out.
module ldtu_ser_nch #(
  parameter int NCH = 4,
  parameter int WORD = 32,
  parameter int HS_OFFSET = 2,
  parameter logic [WORD-1:0] IDLE_PATTERN = WORD'(32'hEAAAAAAA)
) (
  input  logic                  clock,
  input  logic                  rst_b,
  input  logic [NCH*WORD-1:0]   data_in,
  input  logic                  data_valid,
  input  logic                  sync_mode,
  input  logic [WORD-1:0]       sync_pattern,
  input  logic [NCH-1:0]        ch_enable,
  input  logic                  msb_first,
  input  logic                  underrun_clr,
  output logic                  handshake,
  output logic [NCH-1:0]        data_out,
  output logic [7:0]            underrun_cnt
);

  localparam int CW = $clog2(WORD);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);
  localparam logic [CW-1:0] HS_CNT = CW'(WORD - 1 - HS_OFFSET);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NCH-1:0][WORD-1:0]    shreg_q, shreg_d;
  logic                        msb_q, msb_d;
  logic [7:0]                  urun_q, urun_d;
  logic                        load;
  logic                        under;

  assign load  = (cnt_q == LAST);
  assign under = load && !sync_mode && !data_valid;

  always_comb begin
    cnt_d = load ? '0 : cnt_q + CW'(1);
  end

  // Direction is latched with the word so a mid-word msb_first
  // change cannot corrupt the word in flight.
  always_comb begin
    msb_d = load ? msb_first : msb_q;
  end

  // Disabled lanes load zero; zero fill keeps them at zero all word.
  always_comb begin
    shreg_d = shreg_q;
    for (int k = 0; k < NCH; k++) begin
      if (load) begin
        if (!ch_enable[k])
          shreg_d[k] = '0;
        else if (sync_mode)
          shreg_d[k] = sync_pattern;
        else if (data_valid)
          shreg_d[k] = data_in[k*WORD +: WORD];
        else
          shreg_d[k] = IDLE_PATTERN;
      end else if (msb_q) begin
        shreg_d[k] = shreg_q[k] << 1;
      end else begin
        shreg_d[k] = shreg_q[k] >> 1;
      end
    end
  end

  always_comb begin
    urun_d = urun_q;
    if (underrun_clr)
      urun_d = '0;
    else if (under && urun_q != 8'hFF)
      urun_d = urun_q + 8'd1;
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      msb_q   <= 1'b1;
      urun_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      msb_q   <= msb_d;
      urun_q  <= urun_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int k = 0; k < NCH; k++)
      data_out[k] = msb_q ? shreg_q[k][WORD-1] : shreg_q[k][0];
  end

  assign handshake    = (cnt_q == HS_CNT);
  assign underrun_cnt = urun_q;

endmodule
